// File: rtl/jk_sync_counter_if.sv
// Control and status bundle for jk_sync_counter: the mode inputs and the counter outputs.
// The master side drives en/up/load/d, and the slave (the counter) returns q/tc/wrap/ovf.
interface jk_sync_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, up, load, d,
    input  q, tc, wrap, ovf
  );

  modport slave (
    input  en, up, load, d,
    output q, tc, wrap, ovf
  );
endinterface

// File: rtl/jk_sync_counter.sv
// Up/down counter built from per-bit JK flip-flops driven by a small mode controller.
// Define JK_COUNTER_SAT_EN to saturate at the terminal value instead of wrapping.
module jk_sync_counter #(
  parameter int unsigned WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  jk_sync_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ModeHold,
    ModeLoad,
    ModeUp,
    ModeDown
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] ns;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_dn;
  logic             tc;
  logic             blocked;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    mode = ModeHold;
    if (bus.load) begin
      mode = ModeLoad;
    end else if (bus.en) begin
      mode = bus.up ? ModeUp : ModeDown;
    end
  end

  // Bit i toggles once every lower bit is 1 (counting up) or 0 (counting down).
  always_comb begin
    logic run_up;
    logic run_dn;
    t_up   = '0;
    t_dn   = '0;
    run_up = 1'b1;
    run_dn = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      t_up[i] = run_up;
      t_dn[i] = run_dn;
      run_up  = run_up & q_q[i];
      run_dn  = run_dn & ~q_q[i];
    end
  end

  assign tc = bus.en & ~bus.load & (bus.up ? (q_q == AllOnes) : (q_q == '0));

`ifdef JK_COUNTER_SAT_EN
  assign blocked = tc;
  assign wrap_d  = 1'b0;
`else
  assign blocked = 1'b0;
  assign wrap_d  = tc;
`endif

  // A terminal-count step sets ovf; load clears it (tc is already 0 while loading).
  assign ovf_d = bus.load ? 1'b0 : (ovf_q | tc);

  always_comb begin
    j = '0;
    k = '0;
    unique case (mode)
      ModeLoad: begin
        j = bus.d;
        k = ~bus.d;
      end
      ModeUp: begin
        j = t_up;
        k = t_up;
      end
      ModeDown: begin
        j = t_dn;
        k = t_dn;
      end
      ModeHold: begin
        j = '0;
        k = '0;
      end
      default: begin
        j = '0;
        k = '0;
      end
    endcase
    if (blocked) begin
      j = '0;
      k = '0;
    end
  end

  // JK characteristic equation, applied bitwise.
  assign ns = (j & ~q_q) | (~k & q_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= ns;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.tc   = tc;
  assign bus.wrap = wrap_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Scoreboard bench for jk_sync_counter: the driver pushes expectations from an arithmetic model,
// and independent monitors pop and compare tc (mid-cycle) and q/wrap/ovf (after each edge).
module tb_jk_sync_counter;

  localparam int unsigned W = 4;
  localparam int          M = 1 << W;

  typedef struct packed {
    logic [W-1:0] q;
    logic         wrap;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst;

  jk_sync_counter_if #(.WIDTH(W)) bus ();

  jk_sync_counter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t st_q[$];
  bit   tc_q[$];

  // Reference model state: plain integers.
  int mq;
  bit mw;
  bit mo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit u, input bit l, input int dd);
    bit   tce;
    int   nq;
    bit   nw;
    bit   no;
    exp_t x;
    @(posedge clk);
    #2;
    rst      = r;
    bus.en   = e;
    bus.up   = u;
    bus.load = l;
    bus.d    = W'(dd);
    tce = e && !l && (u ? (mq == M - 1) : (mq == 0));
    tc_q.push_back(tce);
    if (r) begin
      nq = 0; nw = 0; no = 0;
    end else if (l) begin
      nq = dd % M; nw = 0; no = 0;
    end else if (e) begin
      if (tce) begin
`ifdef JK_COUNTER_SAT_EN
        nq = mq; nw = 0; no = 1;
`else
        nq = (mq + (u ? 1 : -1) + M) % M; nw = 1; no = 1;
`endif
      end else begin
        nq = (mq + (u ? 1 : -1) + M) % M; nw = 0; no = mo;
      end
    end else begin
      nq = mq; nw = 0; no = mo;
    end
    x.q    = W'(nq);
    x.wrap = nw;
    x.ovf  = no;
    st_q.push_back(x);
    mq = nq; mw = nw; mo = no;
  endtask

  // State monitor: q/wrap/ovf just after each edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        x = st_q.pop_front();
        check("q", int'(bus.q), int'(x.q));
        check("wrap", int'(bus.wrap), int'(x.wrap));
        check("ovf", int'(bus.ovf), int'(x.ovf));
      end
    end
  end

  // Terminal-count monitor: combinational output mid-cycle.
  initial begin
    bit t;
    forever begin
      @(negedge clk);
      if (tc_q.size() > 0) begin
        t = tc_q.pop_front();
        check("tc", int'(bus.tc), int'(t));
      end
    end
  end

  initial begin
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.up   = 1'b0;
    bus.load = 1'b0;
    bus.d    = '0;
    repeat (2) @(posedge clk);
    mq = 0; mw = 0; mo = 0;

    // Reset, then a full up-count around the wrap.
    cycle(1, 0, 1, 0, 0);
    for (int i = 0; i < 18; i++) cycle(0, 1, 1, 0, 0);
    // Down from 0 after reset.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
    // Load with en=0, then hold.
    cycle(0, 0, 1, 1, 10);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
    // Load at the terminal value wins over the step; then rst while enabled.
    cycle(0, 0, 1, 1, 15);
    cycle(0, 1, 1, 1, 3);
    cycle(0, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 0);
    // Count to 7, then reverse.
    for (int i = 0; i < 7; i++) cycle(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
    // en=0 at terminal value.
    cycle(0, 0, 1, 1, 15);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    // Run into the top from 13 (saturation case when enabled).
    cycle(0, 0, 1, 1, 13);
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 0, 1, 2);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(39) == 0), ($urandom_range(3) != 0), 1'($urandom_range(1)),
            ($urandom_range(11) == 0), int'($urandom_range(M - 1)));
    end

    @(posedge clk);
    #3;
    check("drain_state", st_q.size(), 0);
    check("drain_tc", tc_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jk_sync_counter.md
# jk_sync_counter

Synchronous up/down counter whose state bits are built as JK flip-flops: each bit's present state is held in a register and its next state is formed from the JK characteristic equation, ns = j·~ps + ~k·ps. It is the stage directly downstream of the JK next-state logic. It registers `ns` on the clock, feeds the stored value back as `ps`, and drives the per-bit `j`/`k` inputs from a small mode controller. The block provides counting, parallel load, terminal-count detection and wrap/overflow reporting for the lab's sequential exercises.

## Interface
- `WIDTH`, 4: number of JK state bits (≥2).
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `en`  input  1  count enable.
- `up`  input  1  direction: 1 = up, 0 = down.
- `load`  input  1  parallel load request.
- `d`  input  WIDTH  load value.
- `q`  output  WIDTH  present state (registered `ps` vector).
- `tc`  output  1  terminal count (combinational).
- `wrap`  output  1  one-cycle pulse when the counter wrapped (registered).
- `ovf`  output  1  sticky overflow/underflow flag (registered).

## Operation
- Every bit i has its own next-state logic: ns[i] = j[i]&~q[i] | ~k[i]&q[i]. On each edge q[i] <= ns[i]. No behavioural `q+1` path is used for state.
- J/K drive per mode, in priority order:
  - rst: q ← 0. wrap ← 0. ovf ← 0. The J/K drive is ignored.
  - load=1: j[i]=d[i], k[i]=~d[i], giving q ← d regardless of `en`. It also clears ovf and wrap.
  - en=1, up=1: toggle mask t[0]=1, t[i]=&q[i-1:0]. j[i]=k[i]=t[i].
  - en=1, up=0: t[0]=1, t[i]=&~q[i-1:0]. j[i]=k[i]=t[i].
  - otherwise: j=k=0, so the counter holds.
- `tc` = en & ~load & (up ? q==all-ones : q==0).
- Arithmetic is modulo 2^WIDTH. Up from all-ones goes to 0. Down from 0 goes to all-ones.
- `wrap` is registered. It is 1 in exactly the cycle after an edge where tc=1 and the counter stepped; otherwise it is 0.
- `ovf` is set on the same edge that sets `wrap`. It stays set until rst or load.
- Direction may change on any cycle. The new `up` applies to the next edge; no other state changes.

## Timing
- Reset values: q=0, tc=0 (q=0 with up=0 gives tc=en, so tc is 0 only while en=0 or up=1), wrap=0, ovf=0.
- Latency: load or count takes effect 1 cycle after the sampling edge. tc has 0-cycle latency from q/en/up/load. wrap and ovf are valid in the same cycle as the wrapped q.
- rst asserted mid-count overrides load and en on that edge. The first count after rst release occurs on the edge where en=1 is sampled.
- load and tc in the same cycle: load wins, and wrap and ovf are not set.
- en=0 at terminal value: no wrap. tc=0.

## Configuration
- `JK_COUNTER_SAT_EN` defined: saturating mode. When tc=1 and a step would occur, all j=k=0 instead, so q holds at all-ones (up) or 0 (down). In this mode:
  - `tc` behaves as specified.
  - `wrap` is never asserted.
  - `ovf` is set on the first blocked step and stays sticky.
- Undefined (default): modulo wrap-around as in Operation.

## Test plan
- Reset, then en=1, up=1 for 16 cycles (WIDTH=4) -> q steps 0,1,…,15,0. tc=1 only while q=15. wrap=1 only in the cycle q returns to 0. ovf=1 from then on.
- rst for 1 cycle, then en=1, up=0 from 0 -> q=15 next cycle. wrap pulses once. ovf=1. Next q=14 with wrap=0.
- load=1, d=4'b1010 with en=0 -> q=10 next cycle, ovf cleared. Then en=0 for 3 cycles -> q holds at 10, tc=0.
- q=15, en=1, up=1, load=1, d=3 in the same cycle -> q=3, wrap=0, ovf=0. Then rst asserted while en=1 -> q=0, ovf=0 on the next edge.
- Count up to 7, flip up=0 for 3 edges -> q=6,5,4. No wrap. The J/K vectors match the toggle masks.
- With `JK_COUNTER_SAT_EN`: count up from 13 for 5 edges -> q=14,15,15,15,15. wrap never asserts. ovf=1 after the first blocked edge.
